// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: per-pipe one-entry holding registers, fixed-priority grant onto the single RF write port.
// Optional anti-starvation promotion is compiled in with `define WB_ARB_STARVE_GUARD_EN.
module wb_port_arbiter #(
    parameter int NUM_PIPES    = 4,
    parameter int DATA_W       = 32,
    parameter int REG_W        = 5,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PIPES-1:0]          pipe_valid_i,
    output logic [NUM_PIPES-1:0]          pipe_ready_o,
    input  logic [NUM_PIPES-1:0]          pipe_wr_i,
    input  logic [NUM_PIPES*REG_W-1:0]    pipe_rd_i,
    input  logic [NUM_PIPES*DATA_W-1:0]   pipe_data_i,
    output logic                          wb_wr_en_o,
    output logic [REG_W-1:0]              wb_rd_o,
    output logic [DATA_W-1:0]             wb_wr_data_o,
    output logic [NUM_PIPES-1:0]          wb_grant_o,
    output logic                          wb_pending_o
);

    logic [NUM_PIPES-1:0] hold_vld_p0;
    logic [NUM_PIPES-1:0] hold_vld_nxt;
    logic [NUM_PIPES-1:0] gnt;
    logic [NUM_PIPES-1:0] accept;
    logic [REG_W-1:0]     hold_rd_p0   [NUM_PIPES];
    logic [DATA_W-1:0]    hold_data_p0 [NUM_PIPES];
    logic [REG_W-1:0]     sel_rd;
    logic [DATA_W-1:0]    sel_data;

    function automatic logic [NUM_PIPES-1:0] lowest_bit(input logic [NUM_PIPES-1:0] v);
        logic [NUM_PIPES-1:0] r;
        r = '0;
        for (int i = NUM_PIPES - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]     wait_cnt [NUM_PIPES];
    logic [NUM_PIPES-1:0] starved;

    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            starved[i] = hold_vld_p0[i] && (wait_cnt[i] == CNT_W'(STARVE_LIMIT));
        end
        gnt = (|starved) ? lowest_bit(starved) : lowest_bit(hold_vld_p0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PIPES; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                if (hold_vld_p0[i] && !gnt[i]) begin
                    if (wait_cnt[i] != CNT_W'(STARVE_LIMIT)) wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end
`else
    always_comb begin
        gnt = lowest_bit(hold_vld_p0);
    end
`endif

    // A draining entry frees its slot in the same cycle, so a granted pipe can refill without a bubble.
    assign pipe_ready_o = ~hold_vld_p0 | gnt;

    always_comb begin
        accept       = pipe_valid_i & pipe_ready_o;
        hold_vld_nxt = '0;
        sel_rd       = '0;
        sel_data     = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            hold_vld_nxt[i] = (hold_vld_p0[i] & ~gnt[i]) | (accept[i] & pipe_wr_i[i]);
            if (gnt[i]) begin
                sel_rd   = hold_rd_p0[i];
                sel_data = hold_data_p0[i];
            end
        end
    end

    // Stage p0: holding registers (payload carries no reset; validity is gated by hold_vld_p0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_p0 <= '0;
        end else begin
            hold_vld_p0 <= hold_vld_nxt;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (accept[i] && pipe_wr_i[i]) begin
                hold_rd_p0[i]   <= pipe_rd_i[i*REG_W +: REG_W];
                hold_data_p0[i] <= pipe_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Stage p1: registered write bus; x0 destinations are consumed but never enable the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_wr_en_o   <= 1'b0;
            wb_rd_o      <= '0;
            wb_wr_data_o <= '0;
            wb_grant_o   <= '0;
            wb_pending_o <= 1'b0;
        end else begin
            wb_pending_o <= |hold_vld_nxt;
            if (|gnt) begin
                wb_grant_o   <= gnt;
                wb_rd_o      <= sel_rd;
                wb_wr_data_o <= sel_data;
                wb_wr_en_o   <= (sel_rd != '0);
            end else begin
                wb_grant_o   <= '0;
                wb_wr_en_o   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_wb_port_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int RW = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    pipe_valid = '0;
    logic [N-1:0]    pipe_wr = '0;
    logic [N*RW-1:0] pipe_rd = '0;
    logic [N*DW-1:0] pipe_data = '0;
    logic [N-1:0]    pipe_ready;
    logic            wb_wr_en;
    logic [RW-1:0]   wb_rd;
    logic [DW-1:0]   wb_wr_data;
    logic [N-1:0]    wb_grant;
    logic            wb_pending;

    wb_port_arbiter #(.NUM_PIPES(N), .DATA_W(DW), .REG_W(RW), .STARVE_LIMIT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe_valid_i (pipe_valid),
        .pipe_ready_o (pipe_ready),
        .pipe_wr_i    (pipe_wr),
        .pipe_rd_i    (pipe_rd),
        .pipe_data_i  (pipe_data),
        .wb_wr_en_o   (wb_wr_en),
        .wb_rd_o      (wb_rd),
        .wb_wr_data_o (wb_wr_data),
        .wb_grant_o   (wb_grant),
        .wb_pending_o (wb_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  grant;
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
        logic          wr_en;
    } wb_t;

    wb_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [N-1:0] g, input int rd, input logic [DW-1:0] d, input logic en);
        wb_t e;
        e.grant = g;
        e.rd    = RW'(rd);
        e.data  = d;
        e.wr_en = en;
        exp_q.push_back(e);
    endtask

    // Monitor: every presented write (grant or enable) must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (wb_grant != '0 || wb_wr_en)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got grant=%0h rd=%0d data=%0h, expected no write", wb_grant, wb_rd, wb_wr_data);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check("wb_grant", 64'(wb_grant), 64'(e.grant));
                check("wb_rd", 64'(wb_rd), 64'(e.rd));
                check("wb_wr_data", 64'(wb_wr_data), 64'(e.data));
                check("wb_wr_en", 64'(wb_wr_en), 64'(e.wr_en));
            end
        end
    end

    task automatic set_pipe(input int p, input int rd, input logic [DW-1:0] d);
        pipe_rd[p*RW +: RW]   = RW'(rd);
        pipe_data[p*DW +: DW] = d;
    endtask

    // One cycle of stimulus starting just after a rising edge; returns which pipes handshook.
    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] w, output logic [N-1:0] acc);
        pipe_valid = v;
        pipe_wr    = w;
        @(negedge clk);
        acc = v & pipe_ready;
        @(posedge clk);
        #1;
        pipe_valid = '0;
        pipe_wr    = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int c = 0;
        while ((wb_pending || exp_q.size() != 0) && c < 60) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain_timeout", 64'(c < 60), 64'(1));
        idle(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] acc;
        int a;
        bit div_pend;
        int guard;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", 64'(wb_wr_en), 64'(0));
        check("rst_grant", 64'(wb_grant), 64'(0));
        check("rst_rd", 64'(wb_rd), 64'(0));
        check("rst_data", 64'(wb_wr_data), 64'(0));
        check("rst_pending", 64'(wb_pending), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(pipe_ready), 64'(4'hF));
        @(posedge clk);
        #1;

        // Single ALU result: write appears two cycles after acceptance
        set_pipe(0, 5, 32'hDEADBEEF);
        push(4'b0001, 5, 32'hDEADBEEF, 1'b1);
        drive(4'b0001, 4'b0001, acc);
        check("alu_accept", 64'(acc), 64'(4'b0001));
        @(negedge clk);
        check("lat_c1_wr_en", 64'(wb_wr_en), 64'(0));
        check("lat_c1_pending", 64'(wb_pending), 64'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_c2_wr_en", 64'(wb_wr_en), 64'(1));
        check("lat_c2_pending", 64'(wb_pending), 64'(0));
        @(posedge clk);
        #1;
        idle(2);

        // Contention: ALU, MUL, DIV together drain in priority order
        set_pipe(0, 1, 32'hA1);
        set_pipe(2, 2, 32'hA2);
        set_pipe(3, 3, 32'hA3);
        push(4'b0001, 1, 32'hA1, 1'b1);
        push(4'b0100, 2, 32'hA2, 1'b1);
        push(4'b1000, 3, 32'hA3, 1'b1);
        drive(4'b1101, 4'b1101, acc);
        check("cont_accept", 64'(acc), 64'(4'b1101));
        @(negedge clk);
        check("cont_ready_c1", 64'(pipe_ready), 64'(4'b0011));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("cont_ready_c2", 64'(pipe_ready), 64'(4'b0111));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("cont_ready_c3", 64'(pipe_ready), 64'(4'b1111));
        @(posedge clk);
        #1;
        wait_drain();

        // LSU streaming without contention
        for (int k = 0; k < 4; k++) begin
            set_pipe(1, 10 + k, 32'h1000 + k);
            push(4'b0010, 10 + k, 32'h1000 + k, 1'b1);
            drive(4'b0010, 4'b0010, acc);
            check("lsu_stream_ready", 64'(acc), 64'(4'b0010));
        end
        wait_drain();

        // x0 destination: granted but no write enable
        set_pipe(2, 0, 32'h55);
        push(4'b0100, 0, 32'h55, 1'b0);
        drive(4'b0100, 4'b0100, acc);
        wait_drain();

        // Non-writing handshake: accepted, never held, never granted
        set_pipe(0, 7, 32'h77);
        drive(4'b0001, 4'b0000, acc);
        check("nowr_accept", 64'(acc), 64'(4'b0001));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("nowr_pending", 64'(wb_pending), 64'(0));
            check("nowr_grant", 64'(wb_grant), 64'(0));
            @(posedge clk);
            #1;
        end

        // DIV held while ALU streams 12 results
`ifdef WB_ARB_STARVE_GUARD_EN
        for (int k = 0; k < 8; k++) push(4'b0001, 16 + k, 32'hA000 + k, 1'b1);
        push(4'b1000, 9, 32'hD1D1, 1'b1);
        for (int k = 8; k < 12; k++) push(4'b0001, 16 + k, 32'hA000 + k, 1'b1);
`else
        for (int k = 0; k < 12; k++) push(4'b0001, 16 + k, 32'hA000 + k, 1'b1);
        push(4'b1000, 9, 32'hD1D1, 1'b1);
`endif
        a = 0;
        div_pend = 1'b1;
        guard = 0;
        set_pipe(3, 9, 32'hD1D1);
        while ((a < 12 || div_pend) && guard < 100) begin
            if (a < 12) set_pipe(0, 16 + a, 32'hA000 + a);
            drive(((a < 12) ? 4'b0001 : 4'b0000) | (div_pend ? 4'b1000 : 4'b0000),
                  4'b1001, acc);
            if (acc[0]) a++;
            if (acc[3]) div_pend = 1'b0;
            guard++;
        end
        check("starve_stim_timeout", 64'(guard < 100), 64'(1));
        wait_drain();

        // Asynchronous reset with three entries held
        set_pipe(0, 1, 32'hB1);
        set_pipe(1, 2, 32'hB2);
        set_pipe(2, 3, 32'hB3);
        drive(4'b0111, 4'b0111, acc);
        check("rstmid_accept", 64'(acc), 64'(4'b0111));
        #1;
        check("rstmid_pending_before", 64'(wb_pending), 64'(1));
        rst_n = 1'b0;
        #1;
        check("rstmid_wr_en", 64'(wb_wr_en), 64'(0));
        check("rstmid_grant", 64'(wb_grant), 64'(0));
        check("rstmid_rd", 64'(wb_rd), 64'(0));
        check("rstmid_data", 64'(wb_wr_data), 64'(0));
        check("rstmid_pending", 64'(wb_pending), 64'(0));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(5);
        check("post_rst_pending", 64'(wb_pending), 64'(0));
        check("post_rst_ready", 64'(pipe_ready), 64'(4'hF));

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port among the parallel execution pipes (ALU, LSU, MUL, DIV) and feeds the writeback-to-issue write bus (wr_en, rd, wr_data).
- Each pipe gets a one-entry holding register with a valid/ready handshake, so losing pipes stall cleanly instead of dropping results.
- Arbitration is fixed priority by pipe ID (ALU=0 highest, DIV=3 lowest), with an optional anti-starvation promotion.

Parameters:
- NUM_PIPES, 4, number of requesting execution pipes; index equals pipe ID and priority.
- DATA_W, 32, result width.
- REG_W, 5, destination register index width.
- STARVE_LIMIT, 8, wait cycles after which a held entry is promoted (optional feature only).

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pipe_valid_i  in  NUM_PIPES  per-pipe result valid.
- pipe_ready_o  out  NUM_PIPES  per-pipe accept.
- pipe_wr_i  in  NUM_PIPES  per-pipe register_write flag.
- pipe_rd_i  in  NUM_PIPES*REG_W  per-pipe destination; pipe i at [i*REG_W +: REG_W].
- pipe_data_i  in  NUM_PIPES*DATA_W  per-pipe result; pipe i at [i*DATA_W +: DATA_W].
- wb_wr_en_o  out  1  register-file write enable (registered).
- wb_rd_o  out  REG_W  write destination (registered).
- wb_wr_data_o  out  DATA_W  write data (registered).
- wb_grant_o  out  NUM_PIPES  one-hot pipe written this cycle (registered; 0 when idle).
- wb_pending_o  out  1  OR of all holding-register valids; used to drain before fence/CSR.

Behaviour:
- Clock and reset: one clock, clk; reset asynchronous and active-low, rst_n.
- Reset state:
  - hold_vld all 0; wb_wr_en_o=0, wb_rd_o=0, wb_wr_data_o=0, wb_grant_o=0, wb_pending_o=0.
  - pipe_ready_o all 1 once reset releases.
  - Reset asserted mid-operation discards every held entry immediately. No partial write is emitted.
- Per-pipe holding register: hold_vld, hold_rd, hold_data.
- Ready rule: pipe_ready_o[i] = !hold_vld[i] | gnt[i]. Combinational from state and the current grant. No dependency on pipe_valid_i.
- Accept rule, pipe_valid_i[i] & pipe_ready_o[i]:
  - pipe_wr_i[i]=1: load the holding register and set hold_vld.
  - pipe_wr_i[i]=0 (store, branch): handshake completes; nothing is held; no port slot is consumed.
- Drain and refill: a granted entry clears hold_vld at the edge unless the same pipe is accepted in the same cycle. In that case the new entry replaces it with no bubble, sustaining 1 result per cycle per uncontended pipe.
- Arbitration (combinational, each cycle): gnt = lowest-index set bit of hold_vld. At most one grant per cycle.
- Output register update at each edge:
  - Some gnt set: wb_grant_o<=gnt; wb_rd_o<=hold_rd; wb_wr_data_o<=hold_data; wb_wr_en_o<=(hold_rd!=0).
  - No grant: wb_wr_en_o<=0 and wb_grant_o<=0; rd and data hold their previous values.
- x0 writes: rd==0 entries are granted and consumed (the grant is visible) but wb_wr_en_o stays 0.
- Latency: result presented and accepted in cycle C, uncontended → wb_wr_en_o high in cycle C+2.
- Contention: k simultaneous held entries drain in k consecutive cycles in priority order. Lower pipes keep pipe_ready_o=0 until drained.
- wb_pending_o: registered copy of |hold_vld_next, i.e. it reflects holding-register occupancy after the current edge.

Optional Feature:
- Macro: WB_ARB_STARVE_GUARD_EN.
- Defined:
  - Each pipe has a wait counter of width $clog2(STARVE_LIMIT+1), reset to 0.
  - The counter increments, saturating, each cycle hold_vld[i] & !gnt[i]. It clears on grant or when hold_vld is 0.
  - Any pipe with count==STARVE_LIMIT is starved. If any are starved, gnt = lowest-index starved pipe, overriding fixed priority.
- Undefined: pure fixed priority; counters and override logic absent.

Test Plan:
- Reset, then an ALU result rd=5 data=0xDEADBEEF with wr=1 in cycle 0 → cycle 2: wb_wr_en_o=1, wb_rd_o=5, wb_wr_data_o=0xDEADBEEF, wb_grant_o=4'b0001.
- ALU rd=1, MUL rd=2, DIV rd=3 valid in the same cycle → writes in 3 consecutive cycles, order rd 1,2,3. MUL ready=0 for 1 cycle; DIV ready=0 for 2 cycles.
- LSU back-to-back 4 results, no contention → 4 consecutive writes, pipe_ready_o[1] held 1 throughout.
- Result with rd=0 from MUL → wb_grant_o=4'b0100, wb_wr_en_o=0. A pipe_wr_i=0 handshake → no grant at all and wb_pending_o stays 0.
- DIV entry held, ALU streaming continuously, guard enabled with STARVE_LIMIT=8 → DIV granted exactly after 8 wait cycles. Guard disabled → DIV waits until the ALU stream stops.
- rst_n dropped while 3 entries are held → all outputs 0 asynchronously; after release no stale write appears and wb_pending_o=0.
